// File: rtl/mem_stage.sv
// Memory stage: executes loads/stores over a req/ack data port with an access timeout,
// and returns writeback results, the fetch redirect and the condition flags.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        branch_i,
  input  logic [31:0] new_pc_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [5:0]  rd_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        reg_write_i,
  input  logic        set_cond_i,
  input  logic        alu_carry_i,
  input  logic        alu_ovf_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_we_o,
  output logic [5:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic [3:0]  alu_cond_out_o,
  output logic        bus_err_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    rd_lat_q, rd_lat_d;
  logic          regw_lat_q, regw_lat_d;
  logic          dmem_req_q, dmem_req_d;
  logic          dmem_we_q, dmem_we_d;
  logic [31:0]   dmem_addr_q, dmem_addr_d;
  logic [31:0]   dmem_wdata_q, dmem_wdata_d;
  logic          wb_valid_q, wb_valid_d;
  logic          wb_we_q, wb_we_d;
  logic [5:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          redirect_q, redirect_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;
  logic [3:0]    cond_q, cond_d;
  logic          bus_err_q, bus_err_d;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    cnt_d         = cnt_q;
    rd_lat_d      = rd_lat_q;
    regw_lat_d    = regw_lat_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    wb_valid_d    = 1'b0;
    wb_we_d       = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    cond_d        = cond_q;
    bus_err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          if (branch_i) begin
            redirect_d    = 1'b1;
            redirect_pc_d = new_pc_i;
          end else begin
            redirect_d = 1'b0;
          end
          if (set_cond_i) begin
            cond_d = {alu_result_i[31], (alu_result_i == 32'd0), alu_carry_i, alu_ovf_i};
          end else begin
            cond_d = cond_q;
          end
          // Both read and write set is a store: the op type is simply mem_write.
          if (mem_read_i || mem_write_i) begin
            state_d      = S_WAIT;
            in_ready_d   = 1'b0;
            cnt_d        = '0;
            rd_lat_d     = rd_i;
            regw_lat_d   = reg_write_i;
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_write_i;
            dmem_addr_d  = alu_result_i;
            dmem_wdata_d = store_data_i;
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_i;
            wb_data_d  = alu_result_i;
            wb_we_d    = reg_write_i && (rd_i != 6'd0);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_ack_i) begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_lat_q;
          if (dmem_we_q) begin
            wb_data_d = 32'd0;
            wb_we_d   = 1'b0;
          end else begin
            wb_data_d = dmem_rdata_i;
            wb_we_d   = regw_lat_q && (rd_lat_q != 6'd0);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_lat_q;
          wb_data_d  = 32'd0;
          bus_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
        dmem_req_d = 1'b0;
        dmem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b1;
      cnt_q         <= '0;
      rd_lat_q      <= 6'd0;
      regw_lat_q    <= 1'b0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= 32'd0;
      dmem_wdata_q  <= 32'd0;
      wb_valid_q    <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_rd_q       <= 6'd0;
      wb_data_q     <= 32'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      cond_q        <= 4'd0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      cnt_q         <= cnt_d;
      rd_lat_q      <= rd_lat_d;
      regw_lat_q    <= regw_lat_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_we_q       <= wb_we_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      cond_q        <= cond_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign dmem_req_o     = dmem_req_q;
  assign dmem_we_o      = dmem_we_q;
  assign dmem_addr_o    = dmem_addr_q;
  assign dmem_wdata_o   = dmem_wdata_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_we_o        = wb_we_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign redirect_o     = redirect_q;
  assign redirect_pc_o  = redirect_pc_q;
  assign alu_cond_out_o = cond_q;
  assign bus_err_o      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan steps followed by randomized
// operations, checked against a transaction-level reference model.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        branch;
  logic [31:0] new_pc;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [5:0]  rd;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        set_cond;
  logic        alu_carry;
  logic        alu_ovf;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [5:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [3:0]  alu_cond_out;
  logic        bus_err;

  int          n_cmp;
  int          n_mis;
  logic [3:0]  cond_m;
  logic [31:0] rpc_m;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .branch_i(branch), .new_pc_i(new_pc), .alu_result_i(alu_result),
    .store_data_i(store_data), .rd_i(rd), .mem_read_i(mem_read),
    .mem_write_i(mem_write), .reg_write_i(reg_write), .set_cond_i(set_cond),
    .alu_carry_i(alu_carry), .alu_ovf_i(alu_ovf), .dmem_req_o(dmem_req),
    .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
    .dmem_ack_i(dmem_ack), .dmem_rdata_i(dmem_rdata), .wb_valid_o(wb_valid),
    .wb_we_o(wb_we), .wb_rd_o(wb_rd), .wb_data_o(wb_data), .redirect_o(redirect),
    .redirect_pc_o(redirect_pc), .alu_cond_out_o(alu_cond_out), .bus_err_o(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 1'b0; branch = 1'b0; new_pc = 32'd0; alu_result = 32'd0;
    store_data = 32'd0; rd = 6'd0; mem_read = 1'b0; mem_write = 1'b0;
    reg_write = 1'b0; set_cond = 1'b0; alu_carry = 1'b0; alu_ovf = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
  endtask

  // Random input noise while the stage is busy; none of it may be accepted.
  task automatic garbage();
    in_valid = 1'($urandom_range(0, 1)); branch = 1'b1; new_pc = $urandom;
    alu_result = $urandom; store_data = $urandom; rd = 6'($urandom);
    mem_read = 1'($urandom_range(0, 1)); mem_write = 1'($urandom_range(0, 1));
    reg_write = 1'b1; set_cond = 1'b1;
    alu_carry = 1'($urandom_range(0, 1)); alu_ovf = 1'($urandom_range(0, 1));
  endtask

  task automatic accept_model(input logic br, input logic [31:0] npc, input logic [31:0] res,
                              input logic sc, input logic cy, input logic ov);
    if (br) rpc_m = npc;
    if (sc) cond_m = {res[31], (res == 32'd0), cy, ov};
  endtask

  task automatic alu_op(input logic br, input logic [31:0] npc, input logic [31:0] res,
                        input logic [5:0] rdv, input logic rw, input logic sc,
                        input logic cy, input logic ov);
    chk("alu_in_ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1; branch = br; new_pc = npc; alu_result = res; store_data = $urandom;
    rd = rdv; mem_read = 1'b0; mem_write = 1'b0; reg_write = rw; set_cond = sc;
    alu_carry = cy; alu_ovf = ov; dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    tick();
    clear_in();
    accept_model(br, npc, res, sc, cy, ov);
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_wb_we", 32'(wb_we), 32'(rw && (rdv != 6'd0)));
    chk("alu_wb_rd", 32'(wb_rd), 32'(rdv));
    chk("alu_wb_data", wb_data, res);
    chk("alu_redirect", 32'(redirect), 32'(br));
    chk("alu_redirect_pc", redirect_pc, rpc_m);
    chk("alu_cond", 32'(alu_cond_out), 32'(cond_m));
    chk("alu_dmem_req", 32'(dmem_req), 32'd0);
    chk("alu_bus_err", 32'(bus_err), 32'd0);
    chk("alu_in_ready_after", 32'(in_ready), 32'd1);
  endtask

  // n_ack = number of WAIT cycles before the ack edge (1..TO); 0 means never ack.
  task automatic mem_op(input logic br, input logic [31:0] npc, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [5:0] rdv, input logic mr,
                        input logic mw, input logic rw, input logic sc, input logic cy,
                        input logic ov, input int n_ack, input logic [31:0] rdata);
    logic st;
    logic tmo;
    int   n;
    st  = mw;
    tmo = (n_ack == 0);
    n   = tmo ? TO : n_ack;
    chk("mem_in_ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1; branch = br; new_pc = npc; alu_result = addr; store_data = sd;
    rd = rdv; mem_read = mr; mem_write = mw; reg_write = rw; set_cond = sc;
    alu_carry = cy; alu_ovf = ov; dmem_ack = 1'b0;
    tick();
    accept_model(br, npc, addr, sc, cy, ov);
    chk("mem_redirect", 32'(redirect), 32'(br));
    for (int k = 1; k <= n; k++) begin
      chk("wait_dmem_req", 32'(dmem_req), 32'd1);
      chk("wait_in_ready", 32'(in_ready), 32'd0);
      chk("wait_dmem_we", 32'(dmem_we), 32'(st));
      chk("wait_dmem_addr", dmem_addr, addr);
      chk("wait_dmem_wdata", dmem_wdata, sd);
      chk("wait_wb_valid", 32'(wb_valid), 32'd0);
      chk("wait_bus_err", 32'(bus_err), 32'd0);
      chk("wait_redirect_pc", redirect_pc, rpc_m);
      chk("wait_cond", 32'(alu_cond_out), 32'(cond_m));
      if (k > 1) chk("wait_redirect", 32'(redirect), 32'd0);
      garbage();
      dmem_ack = (!tmo && (k == n));
      dmem_rdata = (k == n) ? rdata : $urandom;
      tick();
    end
    clear_in();
    chk("done_dmem_req", 32'(dmem_req), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd1);
    chk("done_wb_valid", 32'(wb_valid), 32'd1);
    chk("done_wb_rd", 32'(wb_rd), 32'(rdv));
    chk("done_bus_err", 32'(bus_err), 32'(tmo));
    chk("done_redirect", 32'(redirect), 32'd0);
    chk("done_cond", 32'(alu_cond_out), 32'(cond_m));
    chk("done_wb_we", 32'(wb_we), 32'(!tmo && !st && rw && (rdv != 6'd0)));
    if (!tmo) chk("done_wb_data", wb_data, st ? 32'd0 : rdata);
  endtask

  task automatic idle_tick();
    clear_in();
    dmem_ack = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    tick();
    dmem_ack = 1'b0;
    chk("idle_wb_valid", 32'(wb_valid), 32'd0);
    chk("idle_wb_we", 32'(wb_we), 32'd0);
    chk("idle_dmem_req", 32'(dmem_req), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_bus_err", 32'(bus_err), 32'd0);
    chk("idle_redirect", 32'(redirect), 32'd0);
    chk("idle_cond", 32'(alu_cond_out), 32'(cond_m));
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    cond_m = 4'd0;
    rpc_m = 32'd0;
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_cond", 32'(alu_cond_out), 32'd0);
    rst = 1'b0;

    alu_op(1'b0, 32'd0, 32'h0000_0005, 6'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("tp_alu_cond_0010", 32'(alu_cond_out), 32'h0000_0002);
    idle_tick();
    mem_op(1'b0, 32'd0, 32'h0000_0100, 32'h0, 6'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
           3, 32'hDEAD_BEEF);
    chk("tp_load_data", wb_data, 32'hDEAD_BEEF);
    mem_op(1'b0, 32'd0, 32'h0000_0200, 32'h0000_1234, 6'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
           1'b0, 2, 32'h5555_AAAA);
    mem_op(1'b0, 32'd0, 32'h0000_0300, 32'h0, 6'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
           0, 32'h0);
    idle_tick();
    mem_op(1'b1, 32'h0000_0040, 32'h0000_0104, 32'h0, 6'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
           1'b0, 1, 32'hCAFE_F00D);
    chk("tp_branch_pc", redirect_pc, 32'h0000_0040);
    alu_op(1'b0, 32'd0, 32'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("tp_zero_flag", 32'(alu_cond_out), 32'h0000_0004);
    mem_op(1'b0, 32'd0, 32'h0000_0400, 32'h0BAD_F00D, 6'd12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
           1'b1, TO, 32'h7777_7777);
    alu_op(1'b1, 32'h0000_1000, 32'h8000_0000, 6'd63, 1'b1, 1'b1, 1'b0, 1'b1);
    alu_op(1'b0, 32'd0, 32'h0000_0001, 6'd1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset asserted while an access is outstanding.
    in_valid = 1'b1; alu_result = 32'h0000_0500; rd = 6'd2; mem_read = 1'b1;
    reg_write = 1'b1;
    tick();
    clear_in();
    tick();
    chk("rstw_dmem_req_pre", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cond_m = 4'd0;
    rpc_m = 32'd0;
    chk("rstw_dmem_req", 32'(dmem_req), 32'd0);
    chk("rstw_in_ready", 32'(in_ready), 32'd1);
    chk("rstw_wb_valid", 32'(wb_valid), 32'd0);
    chk("rstw_cond", 32'(alu_cond_out), 32'd0);
    chk("rstw_redirect_pc", redirect_pc, 32'd0);
    mem_op(1'b0, 32'd0, 32'h0000_0600, 32'h0, 6'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
           0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      int          kind;
      logic [5:0]  r;
      logic [31:0] res;
      kind = $urandom_range(0, 3);
      r    = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      res  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (kind == 0) begin
        alu_op(1'($urandom_range(0, 1)), $urandom, res, r, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        mem_op(1'($urandom_range(0, 1)), $urandom, res, $urandom, r,
               (kind != 2) ? 1'b1 : 1'($urandom_range(0, 1)), (kind == 2),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, TO), $urandom);
      end
      if ($urandom_range(0, 2) == 0) idle_tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline. It consumes the registered outputs of the execute stage, performs loads and stores through a request/acknowledge data-memory port, and presents writeback results. It also returns two things to the front of the pipe: the condition flags that execute consumes as `alu_cond`, and the branch redirect to fetch. It back-pressures execute with `in_ready` while a memory access is outstanding.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles spent waiting for `dmem_ack` before the access is abandoned.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: execute-latch contents are valid this cycle.
- `in_ready` out 1: stage can accept; a transfer occurs when `in_valid && in_ready`.
- `branch` in 1: branch taken (from execute latch).
- `new_pc` in 32: branch target.
- `alu_result` in 32: ALU result; also the memory address.
- `store_data` in 32: data for stores.
- `rd` in 6: destination register.
- `mem_read` in 1: operation is a load.
- `mem_write` in 1: operation is a store.
- `reg_write` in 1: operation writes `rd`.
- `set_cond` in 1: update the condition flags.
- `alu_carry` in 1: ALU carry-out.
- `alu_ovf` in 1: ALU overflow.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: request is a write.
- `dmem_addr` out 32: memory address.
- `dmem_wdata` out 32: write data.
- `dmem_ack` in 1: memory completed the request.
- `dmem_rdata` in 32: load data, valid when `dmem_ack` is high.
- `wb_valid` out 1: one-cycle pulse per retired operation.
- `wb_we` out 1: register-file write enable, qualified by `wb_valid`.
- `wb_rd` out 6: writeback destination.
- `wb_data` out 32: writeback data.
- `redirect` out 1: one-cycle pulse that redirects fetch.
- `redirect_pc` out 32: redirect target.
- `alu_cond_out` out 4: condition flags {N,Z,C,V} returned to execute.
- `bus_err` out 1: one-cycle pulse on access timeout.

## Operation
- States: IDLE and WAIT.
  - `in_ready` is 1 only in IDLE (registered state, not combinational on `dmem_ack`).
- IDLE, transfer with neither `mem_read` nor `mem_write`:
  - Stay in IDLE.
  - Next cycle: `wb_valid`=1, `wb_data`=`alu_result`, `wb_rd`=`rd`, `wb_we`=`reg_write && rd!=0`.
- IDLE, transfer with `mem_read` or `mem_write`:
  - Latch `alu_result`, `store_data`, `rd`, `reg_write` and the op type.
  - Go to WAIT; clear the timeout counter.
  - `mem_read && mem_write` together is treated as a store.
- WAIT:
  - `dmem_req`=1, with `dmem_addr`, `dmem_wdata` and `dmem_we` held constant from the latched values.
  - The counter increments each cycle that `dmem_ack` is 0.
- WAIT, `dmem_ack`=1:
  - Next cycle: `dmem_req`=0, state IDLE, `wb_valid`=1, `wb_rd`=latched rd.
  - Load: `wb_data`=`dmem_rdata` captured on the ack edge, `wb_we`=`reg_write && rd!=0`.
  - Store: `wb_we`=0, `wb_data`=0.
- WAIT, counter reaches `TIMEOUT`-1 with no ack:
  - Next cycle: `dmem_req`=0, `bus_err`=1, `wb_valid`=1 with `wb_we`=0, state IDLE.
  - A `dmem_ack` arriving on that same edge wins over the timeout.
- Branch: on a transfer with `branch`=1, the next cycle has `redirect`=1 and `redirect_pc`=`new_pc`. This is independent of any memory operation in the same transfer.
- Flags: on a transfer with `set_cond`=1, the next cycle loads `alu_cond_out` with:
  - N=`alu_result[31]`
  - Z=(`alu_result`==0)
  - C=`alu_carry`
  - V=`alu_ovf`
  - Otherwise the flags hold.
- `dmem_ack` outside WAIT is ignored.
- Register 0 is hardwired: `wb_we` is never 1 with `wb_rd`=0.

## Timing
- Reset values:
  - State IDLE, so `in_ready`=1.
  - `dmem_req`, `dmem_we`, `wb_valid`, `wb_we`, `redirect`, `bus_err` = 0.
  - `dmem_addr`, `dmem_wdata`, `wb_data`, `wb_rd`, `redirect_pc`, `alu_cond_out` = 0.
- Reset asserted in WAIT: `dmem_req` drops on that edge, no writeback, and the counter clears.
- All outputs are registered.
- Non-memory op accepted at edge T: result visible after T; throughput is one op per cycle.
- Memory op accepted at edge T: `dmem_req` is high from T. If the ack is sampled at edge A, `wb_valid` and `in_ready` are high after A, so the next op can be accepted at A+1.
  - Minimum occupancy: 2 cycles per memory op.
  - Maximum occupancy: `TIMEOUT`+1 cycles per memory op.
- `wb_valid`, `redirect` and `bus_err` are each exactly one cycle wide per event.

## Test plan
- Reset, then an ALU op with `alu_result`=0x0000_0005, rd=3, reg_write=1, set_cond=1, carry=1 -> next cycle `wb_valid`=1, `wb_we`=1, `wb_rd`=3, `wb_data`=5, `alu_cond_out`=4'b0010.
- Load addr 0x100, rd=7, with ack after 3 WAIT cycles and rdata 0xDEAD_BEEF -> `dmem_req` high for exactly 3 cycles, `in_ready` low during them, then `wb_data`=0xDEAD_BEEF and `wb_we`=1.
- Store addr 0x200, data 0x1234 -> `dmem_we`=1 and `dmem_wdata`=0x1234 held until ack, then `wb_valid`=1 with `wb_we`=0.
- Load with ack never asserted, `TIMEOUT`=4 -> `dmem_req` high for exactly 4 cycles, then a `bus_err` pulse, `wb_we`=0, and `in_ready` back to 1.
- Branch with new_pc=0x40 in the same transfer as a load -> `redirect`=1 and `redirect_pc`=0x40 the next cycle, while the load completes normally.
- ALU op with rd=0 and reg_write=1, result 0 -> `wb_we`=0 and Z=1. Reset asserted during WAIT -> `dmem_req`=0 and `in_ready`=1 next cycle.
